// File: rtl/flsh_pkg.sv
// Shared types and default parameters for the flasher time-sharing scheduler.
//   flsh_state_e : scheduler state (IDLE, CLEAR, RUN)
//   *_DEF        : default lamp width, slice length and handover reset length
package flsh_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } flsh_state_e;

    localparam int unsigned MX_LP_DEF   = 16;
    localparam int unsigned SLICE_DEF   = 64;
    localparam int unsigned CLR_CYC_DEF = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index; search runs upward from here and wraps
//   mask  : eligibility mask applied to req
//   pick  : one-hot winner (all zero when nothing eligible)
//   valid : a winner exists
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    logic [NREQ-1:0] cand;
    int unsigned     idx;
    logic [PW-1:0]   sel;

    always_comb begin
        cand  = req & mask;
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = PW'(idx);
            if (!valid && cand[sel]) begin
                pick[sel] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_scheduler.sv
// Time-shares one bound_flasher lamp bank between NREQ requesters.
// A round-robin grant owns the bank for at least SLICE RUN cycles; every handover holds
// the flasher in reset for CLR_CYC cycles before the new owner's flick is routed through.
//   clk, rst   : clock, synchronous active-high reset
//   req        : level request per requester
//   rel        : early-release pulse (owner's bit only)
//   flick_in   : per-requester flick
//   lamp_in    : lamp word from the flasher
//   gnt        : registered one-hot owner, 0 in IDLE
//   fl_rst_n   : registered flasher reset, high only in RUN
//   fl_flick   : owner's flick in RUN, else 0
//   lamp_out   : lamp_in in RUN, else 0
//   busy       : state != IDLE
module flash_scheduler
    import flsh_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned SLICE   = SLICE_DEF,
    parameter int unsigned CLR_CYC = CLR_CYC_DEF,
    parameter int unsigned MX_LP   = MX_LP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rel,
    input  logic [NREQ-1:0]  flick_in,
    input  logic [MX_LP-1:0] lamp_in,
    output logic [NREQ-1:0]  gnt,
    output logic             fl_rst_n,
    output logic             fl_flick,
    output logic [MX_LP-1:0] lamp_out,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(SLICE + 1);
    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned CLR_W = $clog2(CLR_CYC + 1);

    flsh_state_e      state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic             fl_rst_n_q, fl_rst_n_d;

    logic             owner_req;
    logic             owner_rel;
    logic             others;
    logic             expire;
    logic             handover;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] pick_ptr;
    logic [NREQ-1:0]  pick_mask;
    logic [NREQ-1:0]  pick;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;

    assign owner_req = req[owner_q];
    assign owner_rel = rel[owner_q];
    assign others    = |(req & ~gnt_q);
    assign expire    = (cnt_q == CNT_W'(SLICE)) && others;
    assign handover  = (state_q == RUN) && (!owner_req || owner_rel || expire);
    assign ptr_next  = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;

    // At handover the search starts past the owner, so a re-requesting owner ranks last;
    // on a pure expiry it is masked out entirely since someone else is known to be waiting.
    assign pick_ptr  = (state_q == RUN) ? ptr_next : ptr_q;
    assign pick_mask = ((state_q == RUN) && expire) ? ~gnt_q : '1;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            clr_q      <= '0;
            fl_rst_n_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            clr_q      <= clr_d;
            fl_rst_n_q <= fl_rst_n_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    clr_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else if (clr_q == CLR_W'(CLR_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            RUN: begin
                if (handover) begin
                    ptr_d = ptr_next;
                    cnt_d = '0;
                    if (pick_valid) begin
                        gnt_d   = pick;
                        owner_d = pick_idx;
                        clr_d   = '0;
                        state_d = CLEAR;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (cnt_q != CNT_W'(SLICE)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        fl_rst_n_d = (state_d == RUN);
    end

    // Outputs
    always_comb begin
        gnt      = gnt_q;
        fl_rst_n = fl_rst_n_q;
        busy     = (state_q != IDLE) && !rst;
        fl_flick = 1'b0;
        lamp_out = '0;
        if ((state_q == RUN) && !rst) begin
            fl_flick = flick_in[owner_q];
            lamp_out = lamp_in;
        end
    end

endmodule

// File: tb/tb_flash_scheduler.sv
module tb_flash_scheduler;

    localparam int NREQ  = 4;
    localparam int SLICE = 64;
    localparam int CLR   = 2;
    localparam int MX    = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req, rel, flick_in;
    logic [MX-1:0]   lamp_in, lamp_out;
    logic [NREQ-1:0] gnt;
    logic            fl_rst_n, fl_flick, busy;

    always #5 clk = ~clk;

    flash_scheduler #(
        .NREQ    (NREQ),
        .SLICE   (SLICE),
        .CLR_CYC (CLR),
        .MX_LP   (MX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .rel      (rel),
        .flick_in (flick_in),
        .lamp_in  (lamp_in),
        .gnt      (gnt),
        .fl_rst_n (fl_rst_n),
        .fl_flick (fl_flick),
        .lamp_out (lamp_out),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = none), remaining reset cycles, age of the run.
    int m_owner, m_clear_left, m_run_age, m_ptr;

    logic [NREQ-1:0] obs_gnt;
    logic            obs_rstn, obs_busy, obs_flick;
    logic [MX-1:0]   obs_lamp;

    typedef struct {
        logic            r;
        logic [NREQ-1:0] rq;
        logic [NREQ-1:0] rl;
        logic [NREQ-1:0] fk;
        logic [MX-1:0]   lp;
        logic [NREQ-1:0] e_gnt;
        logic            e_rstn;
        logic            e_busy;
        logic            e_flick;
        logic [MX-1:0]   e_lamp;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0] g;
        logic            rn;
        int              len;
    } seg_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_clear_left = 0; m_run_age = 0; m_ptr = 0;
    endtask

    task automatic model_step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] rl);
        int p;
        logic [NREQ-1:0] oth;
        if (r) begin
            model_reset();
        end else if (m_owner < 0) begin
            p = rr(rq, m_ptr);
            if (p >= 0) begin
                m_owner = p; m_clear_left = CLR;
            end
        end else if (m_clear_left > 0) begin
            if (!rq[m_owner]) begin
                m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_clear_left = 0;
            end else begin
                m_clear_left--;
                if (m_clear_left == 0) m_run_age = 0;
            end
        end else begin
            oth = rq;
            oth[m_owner] = 1'b0;
            if (!rq[m_owner] || rl[m_owner] || (m_run_age >= SLICE && oth != 0)) begin
                m_ptr = (m_owner + 1) % NREQ;
                p = rr(rq, m_ptr);
                m_run_age = 0;
                if (p >= 0) begin
                    m_owner = p; m_clear_left = CLR;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_run_age++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [NREQ-1:0] e_gnt;
        logic            e_run;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        e_run = !rst && m_owner >= 0 && m_clear_left == 0;
        cmp({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        cmp({tag, ".fl_rst_n"}, 32'(fl_rst_n), 32'(m_owner >= 0 && m_clear_left == 0));
        cmp({tag, ".busy"}, 32'(busy), 32'(!rst && m_owner >= 0));
        cmp({tag, ".fl_flick"}, 32'(fl_flick), 32'(e_run && flick_in[m_owner < 0 ? 0 : m_owner]));
        cmp({tag, ".lamp_out"}, 32'(lamp_out), 32'(e_run ? lamp_in : '0));
    endtask

    // One clock: drive at the falling edge, check 1 ns later, advance model at the rising edge.
    task automatic drive(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] rl,
                         input logic [NREQ-1:0] fk, input logic [MX-1:0] lp, input string tag);
        rst = r; req = rq; rel = rl; flick_in = fk; lamp_in = lp;
        #1;
        check_model(tag);
        obs_gnt = gnt; obs_rstn = fl_rst_n; obs_busy = busy; obs_flick = fl_flick; obs_lamp = lamp_out;
        @(posedge clk);
        model_step(r, rq, rl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, '0, '0, "rst");
    endtask

    vec_t vt[13];
    seg_t segs[$];
    seg_t exp_segs[$];
    logic [NREQ-1:0] q_g[$];
    logic            q_r[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; rel = '0; flick_in = '0; lamp_in = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();

        // Directed vectors: reset, grant latency, CLEAR length, flick/lamp routing, rel, abort.
        vt[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[1]  = '{1'b0, 4'h1, 4'h0, 4'h1, 16'hA5A5, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[2]  = '{1'b0, 4'h1, 4'h0, 4'h1, 16'hA5A5, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[3]  = '{1'b0, 4'h1, 4'h0, 4'h1, 16'hA5A5, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[4]  = '{1'b0, 4'h1, 4'h0, 4'h1, 16'hA5A5, 4'h1, 1'b1, 1'b1, 1'b1, 16'hA5A5};
        vt[5]  = '{1'b0, 4'h1, 4'h0, 4'hE, 16'h1234, 4'h1, 1'b1, 1'b1, 1'b0, 16'h1234};
        vt[6]  = '{1'b0, 4'h3, 4'h1, 4'h2, 16'h1234, 4'h1, 1'b1, 1'b1, 1'b0, 16'h1234};
        vt[7]  = '{1'b0, 4'h2, 4'h0, 4'h2, 16'h1234, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[8]  = '{1'b0, 4'h0, 4'h0, 4'h2, 16'h1234, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[9]  = '{1'b0, 4'h3, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[10] = '{1'b0, 4'h3, 4'h0, 4'h0, 16'h0000, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[11] = '{1'b1, 4'h3, 4'h0, 4'h0, 16'h0000, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000};
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].r, vt[i].rq, vt[i].rl, vt[i].fk, vt[i].lp, $sformatf("vec%0d", i));
            cmp($sformatf("tab%0d.gnt", i), 32'(obs_gnt), 32'(vt[i].e_gnt));
            cmp($sformatf("tab%0d.rstn", i), 32'(obs_rstn), 32'(vt[i].e_rstn));
            cmp($sformatf("tab%0d.busy", i), 32'(obs_busy), 32'(vt[i].e_busy));
            cmp($sformatf("tab%0d.flick", i), 32'(obs_flick), 32'(vt[i].e_flick));
            cmp($sformatf("tab%0d.lamp", i), 32'(obs_lamp), 32'(vt[i].e_lamp));
        end

        // Reset held 3 cycles in the middle of a run, then a fresh request.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b0, 4'h1, '0, '0, '0, "pre_rst");
        drive(1'b1, 4'h1, '0, '0, '0, "rst_a");
        drive(1'b1, 4'h1, '0, '0, '0, "rst_b");
        cmp("midrun_rst.gnt", 32'(obs_gnt), 32'h0);
        cmp("midrun_rst.rstn", 32'(obs_rstn), 32'h0);
        cmp("midrun_rst.busy", 32'(obs_busy), 32'h0);
        drive(1'b1, 4'h1, '0, '0, '0, "rst_c");
        drive(1'b0, 4'h1, '0, '0, '0, "rel_rst");
        drive(1'b0, 4'h1, '0, '0, '0, "post_rst");
        cmp("post_rst.gnt", 32'(obs_gnt), 32'h1);

        // Single requester keeps the bank well past its slice.
        do_reset();
        for (int i = 0; i < 1 + CLR + SLICE + 100; i++) drive(1'b0, 4'h1, '0, '0, '0, "solo");
        cmp("solo.gnt", 32'(obs_gnt), 32'h1);
        cmp("solo.rstn", 32'(obs_rstn), 32'h1);

        // All requesting: check rotation and segment lengths.
        do_reset();
        q_g.delete(); q_r.delete();
        for (int i = 0; i < 1 + 4 * (CLR + SLICE + 1) + CLR + 3; i++) begin
            drive(1'b0, 4'hF, '0, '0, '0, "rot");
            q_g.push_back(obs_gnt);
            q_r.push_back(obs_rstn);
        end
        segs.delete();
        for (int i = 0; i < q_g.size(); i++) begin
            if (segs.size() != 0 && segs[$].g == q_g[i] && segs[$].rn == q_r[i]) begin
                segs[$].len++;
            end else begin
                segs.push_back('{q_g[i], q_r[i], 1});
            end
        end
        exp_segs.delete();
        exp_segs.push_back('{4'h0, 1'b0, 1});
        for (int k = 0; k < 4; k++) begin
            logic [NREQ-1:0] g;
            g = '0;
            g[k] = 1'b1;
            exp_segs.push_back('{g, 1'b0, CLR});
            exp_segs.push_back('{g, 1'b1, SLICE + 1});
        end
        exp_segs.push_back('{4'h1, 1'b0, CLR});
        exp_segs.push_back('{4'h1, 1'b1, 3});
        cmp("rot.nseg", 32'(segs.size()), 32'(exp_segs.size()));
        for (int i = 0; i < exp_segs.size() && i < segs.size(); i++) begin
            cmp($sformatf("rot%0d.gnt", i), 32'(segs[i].g), 32'(exp_segs[i].g));
            cmp($sformatf("rot%0d.rstn", i), 32'(segs[i].rn), 32'(exp_segs[i].rn));
            cmp($sformatf("rot%0d.len", i), 32'(segs[i].len), 32'(exp_segs[i].len));
        end

        // Owner 1 releases early at run cycle 5 while 0 and 2 request.
        do_reset();
        for (int i = 0; i < 1 + CLR + 5; i++) drive(1'b0, 4'h2, '0, '0, '0, "relpre");
        drive(1'b0, 4'h5, 4'h2, '0, '0, "rel");
        drive(1'b0, 4'h5, '0, '0, '0, "rel_c1");
        cmp("rel_c1.gnt", 32'(obs_gnt), 32'h4);
        cmp("rel_c1.rstn", 32'(obs_rstn), 32'h0);
        drive(1'b0, 4'h5, '0, '0, '0, "rel_c2");
        cmp("rel_c2.rstn", 32'(obs_rstn), 32'h0);
        drive(1'b0, 4'h5, '0, '0, '0, "rel_run");
        cmp("rel_run.gnt", 32'(obs_gnt), 32'h4);
        cmp("rel_run.rstn", 32'(obs_rstn), 32'h1);

        // Owner drops during CLEAR: abort, flasher stays in reset throughout.
        do_reset();
        drive(1'b0, 4'h1, '0, '0, '0, "ab_idle");
        drive(1'b0, 4'h0, '0, '0, '0, "ab_c1");
        cmp("ab_c1.gnt", 32'(obs_gnt), 32'h1);
        begin
            logic ever_hi;
            ever_hi = obs_rstn;
            for (int i = 0; i < 5; i++) begin
                drive(1'b0, 4'h0, '0, '0, '0, "ab_after");
                ever_hi |= obs_rstn;
            end
            cmp("abort.gnt", 32'(obs_gnt), 32'h0);
            cmp("abort.busy", 32'(obs_busy), 32'h0);
            cmp("abort.never_run", 32'(ever_hi), 32'h0);
        end

        // Random traffic against the reference model.
        do_reset();
        begin
            logic [NREQ-1:0] rq, rl;
            logic r;
            rq = '0;
            for (int c = 0; c < 4000; c++) begin
                for (int b = 0; b < NREQ; b++) begin
                    if ($urandom_range(47) == 0) rq[b] = ~rq[b];
                end
                rl = '0;
                for (int b = 0; b < NREQ; b++) begin
                    if ($urandom_range(39) == 0) rl[b] = 1'b1;
                end
                r = ($urandom_range(599) == 0);
                drive(r, rq, rl, NREQ'($urandom), MX'($urandom), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
